// File: rtl/rvdff_skid_if.sv
// rtl/rvdff_skid_if.sv - valid/ready handshake bundle between producer, skid slice and consumer
interface rvdff_skid_if #(parameter int WIDTH = 6) ();
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             dout_ready;
    logic [1:0]       count;

    modport master (
        output din, din_valid, dout_ready,
        input  din_ready, dout, dout_valid, count
    );

    modport slave (
        input  din, din_valid, dout_ready,
        output din_ready, dout, dout_valid, count
    );
endinterface

// File: rtl/rvdff_skid.sv
// rtl/rvdff_skid.sv - two-entry elastic register slice (skid buffer) with registered ready
module rvdff_skid #(
    parameter int WIDTH = 6
) (
    input logic          clk,
    input logic          rst,
    rvdff_skid_if.slave  bus
);
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b10
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] head_q;
    logic [WIDTH-1:0] skid_q;
    logic             push;
    logic             pop;
    logic             load_head_din;
    logic             load_head_skid;
    logic             load_skid;

    // Ready is decoded from state alone so the consumer's ready never reaches the producer.
    assign bus.din_ready  = (state_q != FULL);
    assign bus.dout_valid = (state_q == ONE) || (state_q == FULL);
    assign bus.dout       = head_q;

    assign push = bus.din_valid & bus.din_ready;
    assign pop  = bus.dout_valid & bus.dout_ready;

    always_comb begin
        state_d        = state_q;
        load_head_din  = 1'b0;
        load_head_skid = 1'b0;
        load_skid      = 1'b0;
        case (state_q)
            EMPTY: begin
                if (push) begin
                    load_head_din = 1'b1;
                    state_d       = ONE;
                end
            end
            ONE: begin
                if (push && pop) begin
                    load_head_din = 1'b1;
                end else if (push) begin
                    load_skid = 1'b1;
                    state_d   = FULL;
                end else if (pop) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    load_head_skid = 1'b1;
                    state_d        = ONE;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    always_comb begin
        case (state_q)
            ONE:     bus.count = 2'd1;
            FULL:    bus.count = 2'd2;
            default: bus.count = 2'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            head_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            if (load_head_din) begin
                head_q <= bus.din;
            end else if (load_head_skid) begin
                head_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= bus.din;
            end
        end
    end
endmodule

// File: tb/tb_rvdff_skid.sv
// tb/tb_rvdff_skid.sv - directed and random scoreboard bench for the skid slice
module tb_rvdff_skid;
    logic clk = 1'b0;
    logic rst = 1'b1;

    rvdff_skid_if #(.WIDTH(6)) bus ();

    rvdff_skid #(.WIDTH(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [5:0] sb_q[$];
    logic [5:0] last_dout = 6'h00;
    logic [5:0] exp_head;
    logic [5:0] step_din;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock of traffic: drive, compare against the queue model, then advance.
    task automatic cycle(input logic v, input logic [5:0] d, input logic r);
        int  size_before;
        bit  exp_pop;
        bit  exp_push;
        bus.din        = d;
        bus.din_valid  = v;
        bus.dout_ready = r;
        #1;
        size_before = sb_q.size();
        check("count", 8'(bus.count), 8'(size_before));
        check("din_ready", 8'(bus.din_ready), 8'(size_before < 2));
        check("dout_valid", 8'(bus.dout_valid), 8'(size_before > 0));
        exp_pop  = (size_before > 0) && r;
        exp_push = v && (size_before < 2);
        if (size_before > 0) begin
            exp_head = sb_q[0];
            check("dout_head", 8'(bus.dout), 8'(exp_head));
        end else begin
            check("dout_hold", 8'(bus.dout), 8'(last_dout));
        end
        if (exp_pop) begin
            last_dout = sb_q.pop_front();
        end
        if (exp_push) begin
            sb_q.push_back(d);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_reset(input int n, input logic v, input logic [5:0] d);
        rst            = 1'b1;
        bus.din        = d;
        bus.din_valid  = v;
        bus.dout_ready = 1'b0;
        repeat (n) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        bus.din_valid = 1'b0;
        sb_q.delete();
        last_dout = 6'h00;
        #1;
        check("rst_dout", 8'(bus.dout), 8'h00);
        check("rst_dout_valid", 8'(bus.dout_valid), 8'h00);
        check("rst_count", 8'(bus.count), 8'h00);
        check("rst_din_ready", 8'(bus.din_ready), 8'h01);
    endtask

    initial begin
        bus.din        = 6'h00;
        bus.din_valid  = 1'b0;
        bus.dout_ready = 1'b0;

        apply_reset(2, 1'b1, 6'h2A);
        cycle(1'b0, 6'h00, 1'b0);

        cycle(1'b1, 6'h15, 1'b1);
        cycle(1'b0, 6'h00, 1'b1);
        cycle(1'b0, 6'h00, 1'b1);

        cycle(1'b1, 6'h01, 1'b0);
        cycle(1'b1, 6'h02, 1'b0);
        cycle(1'b1, 6'h03, 1'b0);
        cycle(1'b1, 6'h03, 1'b0);
        cycle(1'b1, 6'h03, 1'b1);
        cycle(1'b1, 6'h03, 1'b1);
        cycle(1'b0, 6'h00, 1'b1);
        cycle(1'b0, 6'h00, 1'b1);

        for (int i = 0; i < 64; i++) begin
            cycle(1'b1, 6'(i), 1'b1);
        end
        cycle(1'b0, 6'h00, 1'b1);
        cycle(1'b0, 6'h00, 1'b1);

        cycle(1'b1, 6'h0A, 1'b0);
        cycle(1'b1, 6'h0B, 1'b1);
        cycle(1'b0, 6'h00, 1'b1);
        cycle(1'b0, 6'h00, 1'b1);

        cycle(1'b1, 6'h11, 1'b0);
        cycle(1'b1, 6'h22, 1'b0);
        check("full_count", 8'(bus.count), 8'h02);
        apply_reset(1, 1'b1, 6'h33);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 6'h00, 1'b1);
        end

        for (int i = 0; i < 300; i++) begin
            step_din = 6'($urandom_range(0, 63));
            cycle(1'($urandom_range(0, 1)), step_din, 1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 6'h00, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
